// File: rtl/alu_pkg.sv
// Shared ALU encodings: control codes, ALUOp classes, R-type funct values and the decoded-op record.
package alu_pkg;

  localparam logic [3:0] AluCtrlAnd  = 4'b0000;
  localparam logic [3:0] AluCtrlOr   = 4'b0001;
  localparam logic [3:0] AluCtrlAdd  = 4'b0010;
  localparam logic [3:0] AluCtrlSub  = 4'b0110;
  localparam logic [3:0] AluCtrlSlt  = 4'b0111;
  localparam logic [3:0] AluCtrlNor  = 4'b1100;
  localparam logic [3:0] AluCtrlNand = 4'b1101;

  localparam logic [2:0] OpAdd   = 3'b000;
  localparam logic [2:0] OpBeq   = 3'b001;
  localparam logic [2:0] OpRtype = 3'b010;
  localparam logic [2:0] OpSlt   = 3'b011;
  localparam logic [2:0] OpOr    = 3'b100;
  localparam logic [2:0] OpAnd   = 3'b101;
  localparam logic [2:0] OpNand  = 3'b110;
  localparam logic [2:0] OpBne   = 3'b111;

  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnNor = 6'h27;
  localparam logic [5:0] FnSlt = 6'h2A;

  typedef struct packed {
    logic [3:0] ctrl;
    logic       illegal;
    logic       br_eq;
    logic       br_ne;
  } dec_op_t;

endpackage

// File: rtl/alu_issue_if.sv
// Request, ALU-side and result signals of alu_issue. br_taken_o exists only with ALU_ISSUE_BRANCH_EN.
interface alu_issue_if #(
  parameter int unsigned DATA_W = 32
);
  logic              in_valid_i;
  logic              in_ready_o;
  logic [2:0]        alu_op_i;
  logic [5:0]        funct_i;
  logic [DATA_W-1:0] src1_i;
  logic [DATA_W-1:0] src2_i;
  logic [DATA_W-1:0] alu_src1_o;
  logic [DATA_W-1:0] alu_src2_o;
  logic [3:0]        alu_ctrl_o;
  logic [DATA_W-1:0] alu_result_i;
  logic              alu_zero_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DATA_W-1:0] result_o;
  logic              zero_o;
  logic              illegal_o;
`ifdef ALU_ISSUE_BRANCH_EN
  logic              br_taken_o;
`endif

  modport slave (
    input  in_valid_i, alu_op_i, funct_i, src1_i, src2_i, alu_result_i, alu_zero_i, out_ready_i,
    output in_ready_o, alu_src1_o, alu_src2_o, alu_ctrl_o, out_valid_o, result_o, zero_o,
`ifdef ALU_ISSUE_BRANCH_EN
    output br_taken_o,
`endif
    output illegal_o
  );

  modport master (
    output in_valid_i, alu_op_i, funct_i, src1_i, src2_i, alu_result_i, alu_zero_i, out_ready_i,
    input  in_ready_o, alu_src1_o, alu_src2_o, alu_ctrl_o, out_valid_o, result_o, zero_o,
`ifdef ALU_ISSUE_BRANCH_EN
    input  br_taken_o,
`endif
    input  illegal_o
  );

endinterface

// File: rtl/alu_ctrl_dec.sv
// Combinational decode of ALUOp/funct into ALU control code, illegal flag and branch kind.
module alu_ctrl_dec
  import alu_pkg::*;
(
  input  logic [2:0] alu_op_i,
  input  logic [5:0] funct_i,
  output dec_op_t    dec_o
);

  always_comb begin
    dec_o      = '0;
    dec_o.ctrl = AluCtrlAdd;
    unique case (alu_op_i)
      OpAdd:  dec_o.ctrl = AluCtrlAdd;
      OpBeq:  begin dec_o.ctrl = AluCtrlSub; dec_o.br_eq = 1'b1; end
      OpRtype: begin
        case (funct_i)
          FnAdd:   dec_o.ctrl = AluCtrlAdd;
          FnSub:   dec_o.ctrl = AluCtrlSub;
          FnAnd:   dec_o.ctrl = AluCtrlAnd;
          FnOr:    dec_o.ctrl = AluCtrlOr;
          FnNor:   dec_o.ctrl = AluCtrlNor;
          FnSlt:   dec_o.ctrl = AluCtrlSlt;
          // Unknown funct still issues (as ADD) so the pipeline keeps moving; the flag marks it.
          default: begin dec_o.ctrl = AluCtrlAdd; dec_o.illegal = 1'b1; end
        endcase
      end
      OpSlt:  dec_o.ctrl = AluCtrlSlt;
      OpOr:   dec_o.ctrl = AluCtrlOr;
      OpAnd:  dec_o.ctrl = AluCtrlAnd;
      OpNand: dec_o.ctrl = AluCtrlNand;
      OpBne:  begin dec_o.ctrl = AluCtrlSub; dec_o.br_ne = 1'b1; end
      default: dec_o.ctrl = AluCtrlAdd;
    endcase
  end

endmodule

// File: rtl/alu_issue.sv
// Two-stage issue (X) / writeback (W) wrapper around an external combinational ALU.
// Optional branch-taken output enabled by defining ALU_ISSUE_BRANCH_EN.
module alu_issue
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input logic        clk_i,
  input logic        rst_i,
  alu_issue_if.slave bus
);

  dec_op_t           w_dec;
  logic              w_free, w_x_adv, w_accept, w_in_ready;
  logic              r_x_valid, r_x_illegal;
  logic [3:0]        r_x_ctrl;
  logic [DATA_W-1:0] r_x_src1, r_x_src2;
  logic              r_w_valid, r_w_zero, r_w_illegal;
  logic [DATA_W-1:0] r_w_result;

  alu_ctrl_dec u_dec (
    .alu_op_i (bus.alu_op_i),
    .funct_i  (bus.funct_i),
    .dec_o    (w_dec)
  );

  assign w_free     = !r_w_valid | bus.out_ready_i;
  assign w_x_adv    = r_x_valid & w_free;
  assign w_in_ready = !r_x_valid | w_free;
  assign w_accept   = bus.in_valid_i & w_in_ready;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_x_valid   <= 1'b0;
      r_x_illegal <= 1'b0;
      r_x_ctrl    <= AluCtrlAdd;
      r_x_src1    <= '0;
      r_x_src2    <= '0;
    end else if (w_accept) begin
      r_x_valid   <= 1'b1;
      r_x_illegal <= w_dec.illegal;
      r_x_ctrl    <= w_dec.ctrl;
      r_x_src1    <= bus.src1_i;
      r_x_src2    <= bus.src2_i;
    end else if (w_x_adv) begin
      r_x_valid   <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_w_valid   <= 1'b0;
      r_w_result  <= '0;
      r_w_zero    <= 1'b0;
      r_w_illegal <= 1'b0;
    end else if (w_x_adv) begin
      r_w_valid   <= 1'b1;
      r_w_result  <= bus.alu_result_i;
      r_w_zero    <= bus.alu_zero_i;
      r_w_illegal <= r_x_illegal;
    end else if (bus.out_ready_i) begin
      r_w_valid   <= 1'b0;
    end
  end

`ifdef ALU_ISSUE_BRANCH_EN
  logic r_x_br_eq, r_x_br_ne, r_w_br_taken;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_x_br_eq    <= 1'b0;
      r_x_br_ne    <= 1'b0;
      r_w_br_taken <= 1'b0;
    end else begin
      if (w_accept) begin
        r_x_br_eq <= w_dec.br_eq;
        r_x_br_ne <= w_dec.br_ne;
      end
      if (w_x_adv) begin
        r_w_br_taken <= (r_x_br_eq & bus.alu_zero_i) | (r_x_br_ne & !bus.alu_zero_i);
      end
    end
  end

  assign bus.br_taken_o = r_w_br_taken;
`else
  logic w_unused_br;
  assign w_unused_br = w_dec.br_eq | w_dec.br_ne;
`endif

  // An idle X presents ADD so the ALU sees a benign code; operands keep their last values.
  assign bus.alu_ctrl_o  = r_x_valid ? r_x_ctrl : AluCtrlAdd;
  assign bus.alu_src1_o  = r_x_src1;
  assign bus.alu_src2_o  = r_x_src2;
  assign bus.in_ready_o  = w_in_ready;
  assign bus.out_valid_o = r_w_valid;
  assign bus.result_o    = r_w_result;
  assign bus.zero_o      = r_w_zero;
  assign bus.illegal_o   = r_w_illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed vector table, backpressure, reset and random stream.
module tb_alu_issue;
  import alu_pkg::*;

  localparam int unsigned DW = 32;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  alu_issue_if #(.DATA_W(DW)) bus ();

  alu_issue #(.DATA_W(DW)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // External combinational ALU driven by the DUT's control code.
  logic [DW-1:0] alu_r;
  always_comb begin
    case (bus.alu_ctrl_o)
      4'b0000: alu_r = bus.alu_src1_o & bus.alu_src2_o;
      4'b0001: alu_r = bus.alu_src1_o | bus.alu_src2_o;
      4'b0010: alu_r = bus.alu_src1_o + bus.alu_src2_o;
      4'b0110: alu_r = bus.alu_src1_o - bus.alu_src2_o;
      4'b0111: alu_r = {31'd0, $signed(bus.alu_src1_o) < $signed(bus.alu_src2_o)};
      4'b1100: alu_r = ~(bus.alu_src1_o | bus.alu_src2_o);
      4'b1101: alu_r = ~(bus.alu_src1_o & bus.alu_src2_o);
      default: alu_r = '0;
    endcase
    bus.alu_result_i = alu_r;
    bus.alu_zero_i   = (alu_r == '0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  typedef enum {KAdd, KSub, KAnd, KOr, KNor, KNand, KSlt} kind_e;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic        ill;
    logic [3:0]  ctrl;
    logic        br;
  } exp_t;

  function automatic exp_t ref_model(input logic [2:0] op, input logic [5:0] fn,
                                     input logic [31:0] a, input logic [31:0] b);
    exp_t  e;
    kind_e k;
    e.ill = 1'b0;
    case (op)
      3'd0: k = KAdd;
      3'd1: k = KSub;
      3'd2: begin
        case (fn)
          6'h20:   k = KAdd;
          6'h22:   k = KSub;
          6'h24:   k = KAnd;
          6'h25:   k = KOr;
          6'h27:   k = KNor;
          6'h2A:   k = KSlt;
          default: begin k = KAdd; e.ill = 1'b1; end
        endcase
      end
      3'd3:    k = KSlt;
      3'd4:    k = KOr;
      3'd5:    k = KAnd;
      3'd6:    k = KNand;
      default: k = KSub;
    endcase
    case (k)
      KAdd:    begin e.res = a + b;              e.ctrl = 4'b0010; end
      KSub:    begin e.res = a - b;              e.ctrl = 4'b0110; end
      KAnd:    begin e.res = a & b;              e.ctrl = 4'b0000; end
      KOr:     begin e.res = a | b;              e.ctrl = 4'b0001; end
      KNor:    begin e.res = ~(a | b);           e.ctrl = 4'b1100; end
      KNand:   begin e.res = ~(a & b);           e.ctrl = 4'b1101; end
      default: begin
        e.res  = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        e.ctrl = 4'b0111;
      end
    endcase
    e.zero = (e.res == 32'd0);
    e.br   = ((op == 3'd1) && e.zero) || ((op == 3'd7) && !e.zero);
    return e;
  endfunction

  typedef struct {
    logic [2:0]  op;
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
    logic        ill;
    logic [3:0]  ctrl;
    logic        br;
  } vec_t;

  vec_t vecs[17];

  task automatic check_reset_vals(input string tag);
    chk({tag, "_out_valid"}, {31'd0, bus.out_valid_o}, 32'd0);
    chk({tag, "_result"},    bus.result_o, 32'd0);
    chk({tag, "_zero"},      {31'd0, bus.zero_o}, 32'd0);
    chk({tag, "_illegal"},   {31'd0, bus.illegal_o}, 32'd0);
    chk({tag, "_ctrl"},      {28'd0, bus.alu_ctrl_o}, 32'h2);
    chk({tag, "_src1"},      bus.alu_src1_o, 32'd0);
    chk({tag, "_src2"},      bus.alu_src2_o, 32'd0);
    chk({tag, "_in_ready"},  {31'd0, bus.in_ready_o}, 32'd1);
`ifdef ALU_ISSUE_BRANCH_EN
    chk({tag, "_br_taken"},  {31'd0, bus.br_taken_o}, 32'd0);
`endif
  endtask

  // Streams n requests; out_ready_i held low for the first hold cycles, then 1 or random.
  task automatic stream(input int n, input int hold, input bit rand_ready);
    exp_t        q[$];
    exp_t        e;
    logic [2:0]  op = '0;
    logic [5:0]  fn = '0;
    logic [31:0] a = '0, b = '0;
    logic [5:0]  legal_fn[6];
    int          sent = 0, acc_hold = 0, cyc = 0;
    bit          have = 1'b0;
    legal_fn = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
    while ((sent < n || q.size() > 0) && cyc < 4000) begin
      @(posedge clk_i); #1;
      if (!have && sent < n) begin
        op   = 3'($urandom_range(0, 7));
        fn   = ($urandom_range(0, 3) == 0) ? 6'($urandom) : legal_fn[$urandom_range(0, 5)];
        a    = $urandom;
        b    = ($urandom_range(0, 3) == 0) ? a : $urandom;
        have = 1'b1;
      end
      bus.in_valid_i  = have;
      bus.alu_op_i    = op;
      bus.funct_i     = fn;
      bus.src1_i      = a;
      bus.src2_i      = b;
      bus.out_ready_i = (cyc < hold) ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
      #1;
      if (bus.out_valid_o && bus.out_ready_i) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL stream_spurious: actual beat %0h required none", bus.result_o);
        end else begin
          e = q.pop_front();
          chk("stream_result",  bus.result_o, e.res);
          chk("stream_zero",    {31'd0, bus.zero_o}, {31'd0, e.zero});
          chk("stream_illegal", {31'd0, bus.illegal_o}, {31'd0, e.ill});
`ifdef ALU_ISSUE_BRANCH_EN
          chk("stream_br",      {31'd0, bus.br_taken_o}, {31'd0, e.br});
`endif
        end
      end
      if (have && bus.in_ready_o) begin
        q.push_back(ref_model(op, fn, a, b));
        sent++;
        have = 1'b0;
        if (cyc < hold) acc_hold++;
      end
      if (hold > 0 && cyc == hold - 1) begin
        chk("bp_accepts", acc_hold, 32'd2);
        chk("bp_in_ready", {31'd0, bus.in_ready_o}, 32'd0);
      end
      cyc++;
    end
    bus.in_valid_i = 1'b0;
    chk("stream_complete", {31'd0, (q.size() == 0) && (sent == n)}, 32'd1);
  endtask

  initial begin
    bus.in_valid_i  = 1'b0;
    bus.alu_op_i    = '0;
    bus.funct_i     = '0;
    bus.src1_i      = '0;
    bus.src2_i      = '0;
    bus.out_ready_i = 1'b1;

    vecs[0]  = '{3'b010, 6'h20, 32'd5,        32'd7,        32'd12,       1'b0, 1'b0, 4'h2, 1'b0};
    vecs[1]  = '{3'b001, 6'h00, 32'd9,        32'd9,        32'd0,        1'b1, 1'b0, 4'h6, 1'b1};
    vecs[2]  = '{3'b111, 6'h00, 32'd9,        32'd9,        32'd0,        1'b1, 1'b0, 4'h6, 1'b0};
    vecs[3]  = '{3'b010, 6'h26, 32'd3,        32'd4,        32'd7,        1'b0, 1'b1, 4'h2, 1'b0};
    vecs[4]  = '{3'b011, 6'h00, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1'b0, 4'h7, 1'b0};
    vecs[5]  = '{3'b010, 6'h27, 32'd0,        32'd0,        32'hFFFFFFFF, 1'b0, 1'b0, 4'hC, 1'b0};
    vecs[6]  = '{3'b000, 6'h00, 32'h64,       32'h17,       32'h7B,       1'b0, 1'b0, 4'h2, 1'b0};
    vecs[7]  = '{3'b100, 6'h00, 32'hF0,       32'h0F,       32'hFF,       1'b0, 1'b0, 4'h1, 1'b0};
    vecs[8]  = '{3'b101, 6'h00, 32'hF0,       32'h3C,       32'h30,       1'b0, 1'b0, 4'h0, 1'b0};
    vecs[9]  = '{3'b110, 6'h00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        1'b1, 1'b0, 4'hD, 1'b0};
    vecs[10] = '{3'b010, 6'h22, 32'd10,       32'd3,        32'd7,        1'b0, 1'b0, 4'h6, 1'b0};
    vecs[11] = '{3'b010, 6'h24, 32'hC,        32'hA,        32'h8,        1'b0, 1'b0, 4'h0, 1'b0};
    vecs[12] = '{3'b010, 6'h25, 32'hC,        32'hA,        32'hE,        1'b0, 1'b0, 4'h1, 1'b0};
    vecs[13] = '{3'b010, 6'h2A, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b1, 1'b0, 4'h7, 1'b0};
    vecs[14] = '{3'b111, 6'h00, 32'd5,        32'd3,        32'd2,        1'b0, 1'b0, 4'h6, 1'b1};
    vecs[15] = '{3'b001, 6'h00, 32'd5,        32'd3,        32'd2,        1'b0, 1'b0, 4'h6, 1'b0};
    vecs[16] = '{3'b000, 6'h3F, 32'd1,        32'd1,        32'd2,        1'b0, 1'b0, 4'h2, 1'b0};

    #2 rst_i = 1'b0;
    #1 check_reset_vals("reset");
    @(posedge clk_i); @(posedge clk_i); #1 rst_i = 1'b1;

    // Directed vectors: one request at a time with the consumer always ready.
    for (int i = 0; i < 17; i++) begin
      @(posedge clk_i); #1;
      bus.in_valid_i = 1'b1;
      bus.alu_op_i   = vecs[i].op;
      bus.funct_i    = vecs[i].fn;
      bus.src1_i     = vecs[i].a;
      bus.src2_i     = vecs[i].b;
      #1 chk("vec_in_ready", {31'd0, bus.in_ready_o}, 32'd1);
      @(posedge clk_i); #1;
      bus.in_valid_i = 1'b0;
      chk("vec_x_ctrl",    {28'd0, bus.alu_ctrl_o}, {28'd0, vecs[i].ctrl});
      chk("vec_x_src1",    bus.alu_src1_o, vecs[i].a);
      chk("vec_x_src2",    bus.alu_src2_o, vecs[i].b);
      chk("vec_early_out", {31'd0, bus.out_valid_o}, 32'd0);
      @(posedge clk_i); #1;
      chk("vec_out_valid", {31'd0, bus.out_valid_o}, 32'd1);
      chk("vec_result",    bus.result_o, vecs[i].res);
      chk("vec_zero",      {31'd0, bus.zero_o}, {31'd0, vecs[i].zero});
      chk("vec_illegal",   {31'd0, bus.illegal_o}, {31'd0, vecs[i].ill});
      chk("vec_idle_ctrl", {28'd0, bus.alu_ctrl_o}, 32'h2);
`ifdef ALU_ISSUE_BRANCH_EN
      chk("vec_br",        {31'd0, bus.br_taken_o}, {31'd0, vecs[i].br});
`endif
    end

    // Backpressure: 4 requests with the consumer stalled for 4 cycles, then drained.
    stream(4, 4, 1'b0);
    // Random traffic with random consumer readiness.
    stream(300, 0, 1'b1);

    repeat (3) @(posedge clk_i);
    #1 chk("drain_idle", {31'd0, bus.out_valid_o}, 32'd0);

    // Reset with both stages full.
    @(posedge clk_i); #1;
    bus.out_ready_i = 1'b0;
    bus.in_valid_i  = 1'b1;
    bus.alu_op_i    = 3'b000;
    bus.src1_i      = 32'd1;
    bus.src2_i      = 32'd2;
    @(posedge clk_i); #1;
    bus.src1_i      = 32'd3;
    bus.src2_i      = 32'd4;
    @(posedge clk_i); #1;
    bus.in_valid_i  = 1'b0;
    chk("full_out_valid", {31'd0, bus.out_valid_o}, 32'd1);
    chk("full_in_ready",  {31'd0, bus.in_ready_o}, 32'd0);
    #2 rst_i = 1'b0;
    #1 check_reset_vals("midrst");
    @(posedge clk_i); #1 rst_i = 1'b1;
    bus.out_ready_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk_i); #1;
      chk("post_rst_no_beat", {31'd0, bus.out_valid_o}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
